// File: rtl/button_event_gen_if.sv
// Button bus for button_event_gen: raw active-low pins in, debounced level and
// one-cycle press/release event pulses out, one bit per button channel.
interface button_event_gen_if #(
  parameter int BTN_NUM = 3
);

  logic [BTN_NUM-1:0] btn_n_i;
  logic [BTN_NUM-1:0] pressed_o;
  logic [BTN_NUM-1:0] press_o;
  logic [BTN_NUM-1:0] release_o;

  // Board / consumer side: drives the pins, consumes the events.
  modport master (
    output btn_n_i,
    input  pressed_o,
    input  press_o,
    input  release_o
  );

  // Conditioner side: samples the pins, produces the events.
  modport slave (
    input  btn_n_i,
    output pressed_o,
    output press_o,
    output release_o
  );

endinterface

// File: rtl/button_event_gen.sv
// button_event_gen: per-channel two-flop synchroniser, counter debouncer and
// press/release event generator for active-low board push-buttons.
// Optional auto-repeat of held buttons is compiled in when the macro
// BTN_AUTOREPEAT_EN is defined; without it each press yields exactly one
// press pulse and no hold/repeat logic exists.
module button_event_gen #(
  parameter int BTN_NUM         = 3,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000
) (
  input logic               clk100_i,
  input logic               rst_i,
  button_event_gen_if.slave btn_bus
);

  // Debounce counter only ever reaches DEBOUNCE_CYCLES-1, so this width holds
  // every value it takes without wrapping.
  localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // Reject parameter values the counters cannot represent or that make no sense.
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 16777215) begin : g_bad_debounce
    $error("button_event_gen: DEBOUNCE_CYCLES must be in 1..2^24-1");
  end
  if (HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_repeat
    $error("button_event_gen: HOLD_CYCLES and REPEAT_CYCLES must be >= 1");
  end

  logic [BTN_NUM-1:0] sync0;
  logic [BTN_NUM-1:0] sync1;
  logic [BTN_NUM-1:0] pressed_q;
  logic [BTN_NUM-1:0] press_q;
  logic [BTN_NUM-1:0] release_q;
  logic [DB_W-1:0]    db_cnt [BTN_NUM];
  logic [BTN_NUM-1:0] accept;
  logic [BTN_NUM-1:0] repeat_fire;

  // Two-flop synchroniser; pins are inverted so 1 means pressed from here on.
  always_ff @(posedge clk100_i) begin
    if (rst_i) begin
      sync0 <= '0;
      sync1 <= '0;
    end else begin
      sync0 <= ~btn_bus.btn_n_i;
      sync1 <= sync0;
    end
  end

  // A channel accepts its new level once it has disagreed with the debounced
  // level for DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    accept = '0;
    for (int k = 0; k < BTN_NUM; k++) begin
      accept[k] = (sync1[k] != pressed_q[k]) && (db_cnt[k] == DB_LAST);
    end
  end

  // Debounce counters and debounced level; any agreeing cycle restarts the count.
  always_ff @(posedge clk100_i) begin
    if (rst_i) begin
      pressed_q <= '0;
      for (int k = 0; k < BTN_NUM; k++) begin
        db_cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < BTN_NUM; k++) begin
        if (sync1[k] == pressed_q[k]) begin
          db_cnt[k] <= '0;
        end else if (accept[k]) begin
          db_cnt[k]    <= '0;
          pressed_q[k] <= sync1[k];
        end else begin
          db_cnt[k] <= db_cnt[k] + DB_W'(1);
        end
      end
    end
  end

  // Event pulses are registered alongside the level so they line up with the
  // first cycle the new level is visible.
  always_ff @(posedge clk100_i) begin
    if (rst_i) begin
      press_q   <= '0;
      release_q <= '0;
    end else begin
      press_q   <= (accept & sync1) | repeat_fire;
      release_q <= accept & ~sync1;
    end
  end

`ifdef BTN_AUTOREPEAT_EN

  // One counter per channel serves both the initial hold delay and the repeat
  // period, so it is sized for the larger of the two.
  localparam int               REP_MAX     = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES
                                                                          : REPEAT_CYCLES;
  localparam int               REP_W       = $clog2(REP_MAX) + 1;
  localparam logic [REP_W-1:0] HOLD_LAST   = REP_W'(HOLD_CYCLES - 1);
  localparam logic [REP_W-1:0] REPEAT_LAST = REP_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    REP_IDLE,
    REP_HOLD,
    REP_REPEAT
  } rep_state_t;

  rep_state_t       rep_state      [BTN_NUM];
  rep_state_t       rep_state_next [BTN_NUM];
  logic [REP_W-1:0] rep_cnt        [BTN_NUM];
  logic [REP_W-1:0] rep_cnt_next   [BTN_NUM];

  // Auto-repeat state and counter registers.
  always_ff @(posedge clk100_i) begin
    if (rst_i) begin
      for (int k = 0; k < BTN_NUM; k++) begin
        rep_state[k] <= REP_IDLE;
        rep_cnt[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < BTN_NUM; k++) begin
        rep_state[k] <= rep_state_next[k];
        rep_cnt[k]   <= rep_cnt_next[k];
      end
    end
  end

  // Auto-repeat sequencing: the counter is 0 in the press-event cycle, a repeat
  // is requested one cycle early so the registered pulse lands on the period,
  // and an accepted release while held returns to idle without firing.
  always_comb begin
    repeat_fire = '0;
    for (int k = 0; k < BTN_NUM; k++) begin
      rep_state_next[k] = rep_state[k];
      rep_cnt_next[k]   = rep_cnt[k];
      case (rep_state[k])
        REP_IDLE: begin
          if (accept[k] && sync1[k]) begin
            rep_state_next[k] = REP_HOLD;
            rep_cnt_next[k]   = '0;
          end
        end
        REP_HOLD: begin
          if (accept[k]) begin
            rep_state_next[k] = REP_IDLE;
            rep_cnt_next[k]   = '0;
          end else if (rep_cnt[k] == HOLD_LAST) begin
            repeat_fire[k]    = 1'b1;
            rep_state_next[k] = REP_REPEAT;
            rep_cnt_next[k]   = '0;
          end else begin
            rep_cnt_next[k] = rep_cnt[k] + REP_W'(1);
          end
        end
        REP_REPEAT: begin
          if (accept[k]) begin
            rep_state_next[k] = REP_IDLE;
            rep_cnt_next[k]   = '0;
          end else if (rep_cnt[k] == REPEAT_LAST) begin
            repeat_fire[k]  = 1'b1;
            rep_cnt_next[k] = '0;
          end else begin
            rep_cnt_next[k] = rep_cnt[k] + REP_W'(1);
          end
        end
        default: begin
          rep_state_next[k] = REP_IDLE;
          rep_cnt_next[k]   = '0;
        end
      endcase
    end
  end

`else

  // Without auto-repeat the only press source is the debouncer itself.
  assign repeat_fire = '0;

`endif

  assign btn_bus.pressed_o = pressed_q;
  assign btn_bus.press_o   = press_q;
  assign btn_bus.release_o = release_q;

endmodule
